// File: rtl/keypad_scan.sv
// keypad_scan
//    Scans a 4x4 active-low matrix keypad one column at a time, paced by an
//    external scan tick, debounces press and release, and reports the
//    accepted key as a 4-bit code with a one-cycle strobe and a held level.
//
// Ports
//    ck       in   1  system clock, rising edge
//    rst_n    in   1  asynchronous active-low reset
//    tick     in   1  scan strobe, one ck wide, spaced >= 4 ck
//    row      in   4  keypad row lines, active-low, asynchronous to ck
//    col      out  4  column drive, active-low, exactly one bit low
//    key      out  4  last accepted key, {row_idx, col_idx}
//    valid    out  1  one-cycle pulse on acceptance of a new key
//    pressed  out  1  high from acceptance until release is accepted
module keypad_scan #(
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic       ck,
   input  logic       rst_n,
   input  logic       tick,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key,
   output logic       valid,
   output logic       pressed
);

   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_TICKS);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   // Index of the lowest-numbered zero bit; lowest row wins on multi-row hits.
   function automatic logic [1:0] low_zero(input logic [3:0] v);
      logic [1:0] idx;
      if (!v[0])      idx = 2'd0;
      else if (!v[1]) idx = 2'd1;
      else if (!v[2]) idx = 2'd2;
      else            idx = 2'd3;
      return idx;
   endfunction

   logic [3:0]    sync_meta_r;
   logic [3:0]    rs_r;
   state_t        state_r, state_next_s;
   logic [1:0]    c_r, c_next_s;
   logic [3:0]    col_r;
   logic [3:0]    cand_r, cand_next_s;
   logic [CW-1:0] cnt_r, cnt_next_s;
   logic [3:0]    key_r, key_next_s;
   logic          valid_r, valid_next_s;
   logic          pressed_r, pressed_next_s;

   logic          hit_s;
   logic [1:0]    r_s;
   logic [CW-1:0] cnt_inc_s;

   assign hit_s     = (rs_r != 4'b1111);
   assign r_s       = low_zero(rs_r);
   assign cnt_inc_s = cnt_r + CNT_ONE;

   assign col     = col_r;
   assign key     = key_r;
   assign valid   = valid_r;
   assign pressed = pressed_r;

   // Two-flop synchronizer for the asynchronous row lines.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta_r <= 4'b1111;
         rs_r        <= 4'b1111;
      end else begin
         sync_meta_r <= row;
         rs_r        <= sync_meta_r;
      end
   end

   // Next-state and output decisions; everything is evaluated only on ticks.
   always_comb begin
      state_next_s   = state_r;
      c_next_s       = c_r;
      cand_next_s    = cand_r;
      cnt_next_s     = cnt_r;
      key_next_s     = key_r;
      valid_next_s   = 1'b0;
      pressed_next_s = pressed_r;
      if (tick) begin
         case (state_r)
            SCAN: begin
               if (hit_s) begin
                  // The column freezes once something is seen on it.
                  cand_next_s = {r_s, c_r};
                  if (CNT_ONE == CNT_DONE) begin
                     key_next_s     = {r_s, c_r};
                     valid_next_s   = 1'b1;
                     pressed_next_s = 1'b1;
                     cnt_next_s     = CNT_ZERO;
                     state_next_s   = HELD;
                  end else begin
                     cnt_next_s   = CNT_ONE;
                     state_next_s = DEBOUNCE;
                  end
               end else begin
                  c_next_s = c_r + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (hit_s && ({r_s, c_r} == cand_r)) begin
                  if (cnt_inc_s == CNT_DONE) begin
                     key_next_s     = cand_r;
                     valid_next_s   = 1'b1;
                     pressed_next_s = 1'b1;
                     cnt_next_s     = CNT_ZERO;
                     state_next_s   = HELD;
                  end else begin
                     cnt_next_s = cnt_inc_s;
                  end
               end else begin
                  // Bounce: retry the same column, do not advance.
                  cnt_next_s   = CNT_ZERO;
                  state_next_s = SCAN;
               end
            end
            HELD: begin
               if (!hit_s) begin
                  if (CNT_ONE == CNT_DONE) begin
                     pressed_next_s = 1'b0;
                     c_next_s       = c_r + 2'd1;
                     cnt_next_s     = CNT_ZERO;
                     state_next_s   = SCAN;
                  end else begin
                     cnt_next_s   = CNT_ONE;
                     state_next_s = RELEASE;
                  end
               end else begin
                  state_next_s = HELD;
               end
            end
            RELEASE: begin
               if (!hit_s) begin
                  if (cnt_inc_s == CNT_DONE) begin
                     pressed_next_s = 1'b0;
                     c_next_s       = c_r + 2'd1;
                     cnt_next_s     = CNT_ZERO;
                     state_next_s   = SCAN;
                  end else begin
                     cnt_next_s = cnt_inc_s;
                  end
               end else begin
                  // Release bounce: back to held, no new strobe.
                  cnt_next_s   = CNT_ZERO;
                  state_next_s = HELD;
               end
            end
            default: begin
               cnt_next_s   = CNT_ZERO;
               state_next_s = SCAN;
            end
         endcase
      end else begin
         state_next_s = state_r;
      end
   end

   // State and output registers; col is stored decoded so it never glitches.
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= SCAN;
         c_r       <= 2'd0;
         col_r     <= 4'b1110;
         cand_r    <= 4'h0;
         cnt_r     <= CNT_ZERO;
         key_r     <= 4'h0;
         valid_r   <= 1'b0;
         pressed_r <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         c_r       <= c_next_s;
         col_r     <= ~(4'b0001 << c_next_s);
         cand_r    <= cand_next_s;
         cnt_r     <= cnt_next_s;
         key_r     <= key_next_s;
         valid_r   <= valid_next_s;
         pressed_r <= pressed_next_s;
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan
//    Directed bench for keypad_scan (DEBOUNCE_TICKS = 4). A small keypad model
//    pulls the rows in press_mask low while column press_col is driven low.
module tb_keypad_scan;

   logic       ck;
   logic       rst_n;
   logic       tick;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key;
   logic       valid;
   logic       pressed;

   logic       press_en;
   logic [3:0] press_mask;
   int         press_col;

   int n_tests;
   int n_fail;
   int vsum;

   keypad_scan #(.DEBOUNCE_TICKS(4)) dut (
      .ck      (ck),
      .rst_n   (rst_n),
      .tick    (tick),
      .row     (row),
      .col     (col),
      .key     (key),
      .valid   (valid),
      .pressed (pressed)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   // Keypad model: selected rows read low only while their column is strobed.
   always_comb begin
      row = 4'b1111;
      if (press_en && (col[press_col] == 1'b0)) row = ~press_mask;
   end

   // Three idle cycles (row settles), then one tick; counts valid cycles seen.
   task automatic do_tick(output int vhits);
      vhits = 0;
      tick  = 1'b0;
      repeat (3) begin
         @(posedge ck); #1;
         if (valid) vhits++;
      end
      tick = 1'b1;
      @(posedge ck); #1;
      tick = 1'b0;
      if (valid) vhits++;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge ck);
      #1;
      n_tests++;
      if (col !== 4'b1110 || key !== 4'h0 || valid !== 1'b0 || pressed !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold: col=%b key=%h valid=%b pressed=%b required 1110 0 0 0", col, key, valid, pressed);
      end
      rst_n = 1'b1;
      @(posedge ck); #1;
      n_tests++;
      if (col !== 4'b1110 || key !== 4'h0 || valid !== 1'b0 || pressed !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: col=%b key=%h valid=%b pressed=%b required 1110 0 0 0", col, key, valid, pressed);
      end
   endtask

   task automatic test_rotation;
      logic [3:0] exp_col [4];
      int vh;
      exp_col[0] = 4'b1101; exp_col[1] = 4'b1011; exp_col[2] = 4'b0111; exp_col[3] = 4'b1110;
      press_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         do_tick(vh);
         n_tests++;
         if (col !== exp_col[i] || vh != 0) begin
            n_fail++;
            $display("FAIL rotation[%0d]: col=%b valid_cycles=%0d required %b 0", i, col, vh, exp_col[i]);
         end
      end
   endtask

   // Bounce on column 2 row 2, then a clean press of the same key (4'hA).
   task automatic test_press;
      int vh;
      press_mask = 4'b0100; press_col = 2; press_en = 1'b1;
      vsum = 0;
      do_tick(vh); vsum += vh;          // col 0 -> 1
      do_tick(vh); vsum += vh;          // col 1 -> 2
      do_tick(vh); vsum += vh;          // detect
      do_tick(vh); vsum += vh;          // second match
      press_en = 1'b0;
      do_tick(vh); vsum += vh;          // bounce: back to scan, column kept
      n_tests++;
      if (col !== 4'b1011 || vsum != 0 || pressed !== 1'b0) begin
         n_fail++;
         $display("FAIL press_bounce: col=%b valid_cycles=%0d pressed=%b required 1011 0 0", col, vsum, pressed);
      end
      press_en = 1'b1;
      for (int i = 0; i < 3; i++) begin // detect on retried column, then two matches
         do_tick(vh); vsum += vh;
      end
      n_tests++;
      if (col !== 4'b1011 || vsum != 0 || pressed !== 1'b0) begin
         n_fail++;
         $display("FAIL press_early: col=%b valid_cycles=%0d pressed=%b required 1011 0 0", col, vsum, pressed);
      end
      do_tick(vh);                      // fourth matching tick
      n_tests++;
      if (vh != 1 || valid !== 1'b1 || key !== 4'hA || pressed !== 1'b1 || col !== 4'b1011) begin
         n_fail++;
         $display("FAIL press_accept: valid_cycles=%0d key=%h pressed=%b col=%b required 1 a 1 1011", vh, key, pressed, col);
      end
      @(posedge ck); #1;
      n_tests++;
      if (valid !== 1'b0) begin
         n_fail++;
         $display("FAIL valid_width: valid=%b required 0", valid);
      end
   endtask

   task automatic test_release;
      int vh;
      vsum = 0;
      do_tick(vh); vsum += vh;          // still held
      press_en = 1'b0;
      do_tick(vh); vsum += vh;
      do_tick(vh); vsum += vh;
      press_en = 1'b1;
      do_tick(vh); vsum += vh;          // back to held
      n_tests++;
      if (pressed !== 1'b1 || vsum != 0 || col !== 4'b1011 || key !== 4'hA) begin
         n_fail++;
         $display("FAIL release_bounce: pressed=%b valid_cycles=%0d col=%b key=%h required 1 0 1011 a", pressed, vsum, col, key);
      end
      press_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         do_tick(vh); vsum += vh;
      end
      n_tests++;
      if (pressed !== 1'b1 || col !== 4'b1011) begin
         n_fail++;
         $display("FAIL release_early: pressed=%b col=%b required 1 1011", pressed, col);
      end
      do_tick(vh); vsum += vh;
      n_tests++;
      if (pressed !== 1'b0 || col !== 4'b0111 || key !== 4'hA || vsum != 0) begin
         n_fail++;
         $display("FAIL release_done: pressed=%b col=%b key=%h valid_cycles=%0d required 0 0111 a 0", pressed, col, key, vsum);
      end
   endtask

   // Rows 1 and 3 on column 0: lowest row wins, key = {2'd1, 2'd0} = 4'h4.
   task automatic test_multi_row;
      int vh;
      press_mask = 4'b1010; press_col = 0; press_en = 1'b1;
      vsum = 0;
      do_tick(vh); vsum += vh;          // col 3 -> 0
      for (int i = 0; i < 3; i++) begin
         do_tick(vh); vsum += vh;
      end
      n_tests++;
      if (vsum != 0 || pressed !== 1'b0 || col !== 4'b1110) begin
         n_fail++;
         $display("FAIL multi_early: valid_cycles=%0d pressed=%b col=%b required 0 0 1110", vsum, pressed, col);
      end
      do_tick(vh);
      n_tests++;
      if (vh != 1 || key !== 4'h4 || pressed !== 1'b1) begin
         n_fail++;
         $display("FAIL multi_accept: valid_cycles=%0d key=%h pressed=%b required 1 4 1", vh, key, pressed);
      end
      press_en = 1'b0;
      for (int i = 0; i < 4; i++) do_tick(vh);
      n_tests++;
      if (pressed !== 1'b0 || col !== 4'b1101 || key !== 4'h4) begin
         n_fail++;
         $display("FAIL multi_release: pressed=%b col=%b key=%h required 0 1101 4", pressed, col, key);
      end
   endtask

   task automatic test_reset_mid;
      int vh;
      press_mask = 4'b0001; press_col = 1; press_en = 1'b1;
      vsum = 0;
      do_tick(vh); vsum += vh;          // detect on column 1
      do_tick(vh); vsum += vh;          // second match
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (col !== 4'b1110 || key !== 4'h0 || valid !== 1'b0 || pressed !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: col=%b key=%h valid=%b pressed=%b required 1110 0 0 0", col, key, valid, pressed);
      end
      repeat (4) begin
         @(posedge ck); #1;
         if (valid) vsum++;
      end
      rst_n = 1'b1;
      do_tick(vh); vsum += vh;          // col 0 -> 1, nothing on column 0
      n_tests++;
      if (col !== 4'b1101) begin
         n_fail++;
         $display("FAIL reset_restart: col=%b required 1101", col);
      end
      press_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         do_tick(vh); vsum += vh;
      end
      n_tests++;
      if (vsum != 0 || pressed !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_valid: valid_cycles=%0d pressed=%b required 0 0", vsum, pressed);
      end
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      vsum       = 0;
      tick       = 1'b0;
      rst_n      = 1'b0;
      press_en   = 1'b0;
      press_mask = 4'b0000;
      press_col  = 0;
      test_reset;
      test_rotation;
      test_press;
      test_release;
      test_multi_row;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Input-side counterpart of the team's multiplexed seven-segment display driver. It scans a 4x4 matrix keypad by strobing one active-low column at a time, paced by an external scan tick, and reads back the four active-low row lines. It debounces press and release, then reports the accepted key as a 4-bit hex code with a one-cycle strobe and a held level. It sits between the board keypad pins and the clock-setting logic, which consumes `key`/`valid`.

## Interface
- `DEBOUNCE_TICKS`, default 4: consecutive matching scan ticks needed to accept a press or a release. Legal range is ≥1. The counter width is $clog2(DEBOUNCE_TICKS+1).

- `ck`  in  1: system clock. All state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `tick`  in  1: scan enable strobe, one `ck` cycle wide. Spacing must be ≥4 `ck` cycles.
- `row`  in  4: keypad row lines, active-low, asynchronous to `ck`.
- `col`  out  4: column drive, active-low, exactly one bit low at all times.
- `key`  out  4: code of the last accepted key, {row_idx[1:0], col_idx[1:0]}.
- `valid`  out  1: one-cycle pulse when a new key is accepted.
- `pressed`  out  1: high from acceptance until the release is accepted.

## Operation
- `row` passes through a 2-flop synchronizer. The synchronizer resets to 4'b1111. All decisions use the synchronized value `rs`, and only in cycles where `tick`=1.
- Column index `c` (0..3) drives `col` = ~(1<<c). It advances (wrapping 3→0) only where stated below.
- Row index `r` is the lowest-numbered zero bit of `rs`. "Hit" means `rs` != 4'b1111.
- A counter `cnt` tracks matching ticks.
- States:
  - SCAN:
    - Tick with no hit: `c` advances.
    - Tick with hit: capture cand={r,c} and set `cnt`=1. `c` is frozen.
    - If DEBOUNCE_TICKS==1, accept immediately (see DEBOUNCE acceptance). Otherwise go to DEBOUNCE.
  - DEBOUNCE:
    - Tick with hit and {r,c}==cand: `cnt`++.
    - When `cnt` reaches DEBOUNCE_TICKS: `key`<=cand, `valid`<=1 for one cycle, `pressed`<=1, go to HELD.
    - Tick with no hit, or a different `r`: go to SCAN with `cnt`=0. `c` is not advanced, so the same column is retried on the next tick.
  - HELD:
    - Tick with hit (any row): stay.
    - Tick with no hit: `cnt`=1, go to RELEASE. If DEBOUNCE_TICKS==1, complete the release immediately.
  - RELEASE:
    - Tick with no hit: `cnt`++.
    - When `cnt` reaches DEBOUNCE_TICKS: `pressed`<=0, `c` advances, go to SCAN.
    - Tick with hit: go to HELD, `cnt`=0. No new `valid`.
- `key` holds its value until the next acceptance. It is not cleared on release.
- Multiple rows low in one column: the lowest row index wins. A second key in another column is ignored while not in SCAN.
- `rst_n` low dominates `tick` in every state.

## Timing
- Reset values:
  - `col`=4'b1110 (`c`=0), `key`=4'h0, `valid`=0, `pressed`=0.
  - State SCAN, `cnt`=0, synchronizer 4'b1111.
  - All are applied asynchronously when `rst_n` falls.
- Reset mid-operation: any pending debounce is discarded. No `valid` is emitted. Scanning restarts at `c`=0 on the first tick after `rst_n` rises.
- Row to decision latency: `row` must be stable ≥2 `ck` before a tick to be seen on that tick.
- Acceptance: `key`, `valid` and `pressed` update on the same `ck` edge where the DEBOUNCE_TICKS-th matching tick is sampled. `valid` is high for exactly that following cycle.
- Press-to-valid: DEBOUNCE_TICKS ticks, counting the detection tick.
- Release: `pressed` falls on the edge of the DEBOUNCE_TICKS-th consecutive no-hit tick. `col` advances on the same edge.
- `valid` is never high on two consecutive cycles.
- `valid` is never high while in RELEASE or SCAN-without-hit.

## Test plan
- Reset/idle rotation:
  - After `rst_n` rises with `row`=4'hF: `col`=1110, `valid`=0, `pressed`=0, `key`=0.
  - Successive ticks give `col` 1101, 1011, 0111, 1110.
- Clean press, DEBOUNCE_TICKS=4:
  - The keypad model pulls `row[2]` low whenever `col[2]`=0.
  - On the 4th tick after detection: `key`=4'hA, a single `valid` pulse, `pressed`=1.
  - `col` stays frozen at 1011.
- Press bounce: `row[2]` low for 2 ticks, then high → return to SCAN with no `valid`, and `col` is retried at 1011 on the next tick.
- Release bounce, continuing from the clean press:
  - `row` high for 2 ticks, then low again → `pressed` stays 1 and there is no `valid`.
  - Then `row` high for 4 ticks → `pressed`=0 and `col`=0111 on the same edge.
- Multi-row: `row[1]` and `row[3]` low while `col`=1110, for 4 ticks → `key`=4'h4.
- Reset mid-debounce: `rst_n` pulled low after 2 matching ticks → all outputs take their reset values immediately and no `valid` is ever seen.
